// File: rtl/keccak_ctrl_fsm_p.sv
// Control FSM for the Keccak-f[1600] datapath: sequences absorb, permute and squeeze
// for SHA3-256/512 and SHAKE128/256 with rounds-per-cycle unrolling and XOF squeeze.
module keccak_ctrl_fsm_p #(
  parameter int unsigned NR_ROUNDS = 24,
  parameter int unsigned RPC       = 1,
  parameter int unsigned LEN_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic [1:0]       mode_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic             state_we,
  output logic             absorb_sel,
  output logic             zero_state,
  output logic             perm_en,
  output logic [4:0]       round_idx,
  output logic [10:0]      rate_bits,
  output logic [1:0]       mode_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_bits,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned NCYC = NR_ROUNDS / RPC;
  localparam int unsigned RC_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NCYC - 1);

  typedef enum logic [2:0] {StInit, StIdle, StAbsorb, StPerm, StSqueeze} state_e;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             sqz_q, sqz_d;
  logic [1:0]       mode_d;
  logic [LEN_W-1:0] rate_ext;
  logic             rem_fits;

  always_comb begin
    unique case (mode_q)
      2'b00:   rate_bits = 11'd1088;
      2'b01:   rate_bits = 11'd576;
      2'b10:   rate_bits = 11'd1344;
      default: rate_bits = 11'd1088;
    endcase
  end

  assign rate_ext  = LEN_W'(rate_bits);
  assign rem_fits  = (rem_q <= rate_ext);
  assign round_idx = 5'(rc_q * RPC);
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    rem_d      = rem_q;
    last_d     = last_q;
    sqz_d      = sqz_q;
    mode_d     = mode_q;
    blk_ready  = 1'b0;
    state_we   = 1'b0;
    absorb_sel = 1'b0;
    zero_state = 1'b0;
    perm_en    = 1'b0;
    out_valid  = 1'b0;
    out_bits   = '0;
    out_last   = 1'b0;

    case (state_q)
      StInit: begin
        zero_state = 1'b1;
        state_we   = 1'b1;
        state_d    = StIdle;
      end

      StIdle: begin
        blk_ready = ~abort;
        if (blk_valid && blk_ready) begin
          mode_d = mode_in;
          unique case (mode_in)
            2'b00:   rem_d = LEN_W'(256);
            2'b01:   rem_d = LEN_W'(512);
            default: rem_d = len_in;
          endcase
          last_d     = blk_last;
          state_we   = 1'b1;
          absorb_sel = 1'b1;
          rc_d       = '0;
          sqz_d      = 1'b0;
          state_d    = StPerm;
        end
      end

      StAbsorb: begin
        blk_ready = ~abort;
        if (blk_valid && blk_ready) begin
          last_d     = blk_last;
          state_we   = 1'b1;
          absorb_sel = 1'b1;
          rc_d       = '0;
          sqz_d      = 1'b0;
          state_d    = StPerm;
        end
      end

      StPerm: begin
        perm_en  = 1'b1;
        state_we = 1'b1;
        if (rc_q == RC_LAST) begin
          rc_d    = '0;
          state_d = (sqz_q || last_q) ? StSqueeze : StAbsorb;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end

      StSqueeze: begin
        out_valid = ~abort;
        out_bits  = rem_fits ? 11'(rem_q) : rate_bits;
        out_last  = rem_fits;
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_d = StInit;
          end else begin
            rem_d   = rem_q - rate_ext;
            sqz_d   = 1'b1;
            rc_d    = '0;
            state_d = StPerm;
          end
        end
      end

      default: state_d = StInit;
    endcase

    if (abort) state_d = StInit;

    // INIT always presents the same context as reset, whatever path led there.
    if (state_d == StInit) begin
      rc_d   = '0;
      rem_d  = '0;
      last_d = 1'b0;
      sqz_d  = 1'b0;
      mode_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
      rc_q    <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      sqz_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      sqz_q   <= sqz_d;
      mode_q  <= mode_d;
    end
  end

endmodule
